regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (write_reg, write_data, reg_write) between two writeback requesters: A is the ALU result path and B is the memory-load path.
- Arbitrates round-robin using valid/ready handshakes and registers the winning write for exactly one cycle.
- Keeps a pending-write scoreboard so issue logic can stall on registers whose results are outstanding.

---
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between an ALU and a load path,
// with a pending-write scoreboard. Define REGFILE_ARB_FWD_EN to add the write-to-read forwarding port.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int NUM_REGS = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [ADDR_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDR_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  output logic                reg_write,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data,
`ifdef REGFILE_ARB_FWD_EN
  input  logic [ADDR_W-1:0]   fwd_reg,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data,
`endif
  output logic [NUM_REGS-1:0] busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state_reg, state_next;
  logic                last_grant_reg, last_grant_next;  // 1 = B won last
  logic [ADDR_W-1:0]   wr_idx_reg;
  logic [DATA_W-1:0]   wr_data_reg;
  logic [NUM_REGS-1:0] busy_reg, busy_next;
  logic                handshake;

  always_comb begin
    a_ready         = 1'b0;
    b_ready         = 1'b0;
    handshake       = 1'b0;
    state_next      = IDLE;
    last_grant_next = last_grant_reg;
    if (a_valid && (!b_valid || last_grant_reg))
      a_ready = 1'b1;
    if (b_valid && (!a_valid || !last_grant_reg))
      b_ready = 1'b1;
    handshake = a_ready || b_ready;
    case (state_reg)
      IDLE:    state_next = handshake ? WRITE : IDLE;
      WRITE:   state_next = handshake ? WRITE : IDLE;
      default: state_next = IDLE;
    endcase
    if (handshake)
      last_grant_next = b_ready;
    // Writes to r0 are staged like any other but never enabled.
    reg_write = (state_reg == WRITE) && (wr_idx_reg != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      wr_idx_reg     <= '0;
      wr_data_reg    <= '0;
      busy_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      busy_reg       <= busy_next;
      if (handshake) begin
        wr_idx_reg  <= b_ready ? b_reg  : a_reg;
        wr_data_reg <= b_ready ? b_data : a_data;
      end
    end
  end

  // A new issue to a register outranks the retiring write to that same register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        assign busy_next[gi] = (issue_valid && (issue_reg == ADDR_W'(gi))) ||
                               (busy_reg[gi] && !(reg_write && (write_reg == ADDR_W'(gi))));
      end
    end
  endgenerate

  assign write_reg  = wr_idx_reg;
  assign write_data = wr_data_reg;
  assign busy       = busy_reg;

`ifdef REGFILE_ARB_FWD_EN
  assign fwd_hit  = reg_write && (write_reg == fwd_reg) && (fwd_reg != '0);
  assign fwd_data = fwd_hit ? write_data : '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the arbiter.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_reg, b_reg, issue_reg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy;
`ifdef REGFILE_ARB_FWD_EN
  logic [4:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
`ifdef REGFILE_ARB_FWD_EN
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file fed by the DUT write port, and the model's view of it.
  logic [31:0] rf     [32] = '{default: '0};
  logic [31:0] exp_rf [32] = '{default: '0};

  always @(posedge clk)
    if (reg_write) rf[write_reg] <= write_data;

  // Behavioural model: pending write from last cycle's acceptance, round-robin pointer, busy set.
  logic        m_last_b;
  logic        m_pend;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  logic        a_wait, b_wait;
  logic [4:0]  a_reg_prev, b_reg_prev;
  logic [31:0] a_data_prev, b_data_prev;

  always @(negedge clk) begin
    logic exp_a, exp_b, exp_rw;
    if (rst) begin
      m_last_b = 1'b1; m_pend = 1'b0; m_idx = '0; m_data = '0; m_busy = '0;
      a_wait = 1'b0; b_wait = 1'b0;
      chk("rst_reg_write", reg_write, 0);
      chk("rst_write_reg", write_reg, 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_busy", busy, 0);
    end else begin
      exp_a  = a_valid && (!b_valid || m_last_b);
      exp_b  = b_valid && (!a_valid || !m_last_b);
      exp_rw = m_pend && (m_idx != 0);
      if (a_wait) begin
        chk("a_hold_valid", a_valid, 1);
        chk("a_hold_reg", a_reg, a_reg_prev);
        chk("a_hold_data", a_data, a_data_prev);
      end
      if (b_wait) begin
        chk("b_hold_valid", b_valid, 1);
        chk("b_hold_reg", b_reg, b_reg_prev);
        chk("b_hold_data", b_data, b_data_prev);
      end
      chk("a_ready", a_ready, exp_a);
      chk("b_ready", b_ready, exp_b);
      chk("reg_write", reg_write, exp_rw);
      chk("write_reg", write_reg, m_idx);
      chk("write_data", write_data, m_data);
      chk("busy", busy, m_busy);
`ifdef REGFILE_ARB_FWD_EN
      chk("fwd_hit", fwd_hit, exp_rw && (m_idx == fwd_reg) && (fwd_reg != 0));
      chk("fwd_data", fwd_data, (exp_rw && (m_idx == fwd_reg) && (fwd_reg != 0)) ? m_data : 0);
`endif
      // Advance to the state after the coming posedge.
      if (exp_rw) begin
        exp_rf[m_idx] = m_data;
        m_busy[m_idx] = 1'b0;
      end
      if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
      if (exp_a) begin
        m_pend = 1'b1; m_idx = a_reg; m_data = a_data; m_last_b = 1'b0;
      end else if (exp_b) begin
        m_pend = 1'b1; m_idx = b_reg; m_data = b_data; m_last_b = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
      a_wait = a_valid && !exp_a; a_reg_prev = a_reg; a_data_prev = a_data;
      b_wait = b_valid && !exp_b; b_reg_prev = b_reg; b_data_prev = b_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic a_took, b_took;
    rst = 1'b1;
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    issue_valid = 0; issue_reg = 0;
`ifdef REGFILE_ARB_FWD_EN
    fwd_reg = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single A write after reset.
    a_valid = 1; a_reg = 3; a_data = 32'h0000FFFF;
    #1 chk("t1_a_ready", a_ready, 1);
    tick(); a_valid = 0;
    #1 chk("t1_reg_write", reg_write, 1);
    chk("t1_write_reg", write_reg, 3);
    chk("t1_write_data", write_data, 32'h0000FFFF);
    tick();
    #1 chk("t1_reg_write_off", reg_write, 0);

    // Contention after a fresh reset: A,B,A,B.
    tick(); rst = 1;
    tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_reg = 5; a_data = 32'hA5A5_0005;
      b_valid = 1; b_reg = 6; b_data = 32'hB6B6_0006;
      #1 chk("t2_a_ready", a_ready, (i % 2) == 0);
      chk("t2_b_ready", b_ready, (i % 2) == 1);
      if (i > 0) begin
        chk("t2_reg_write", reg_write, 1);
        chk("t2_write_reg", write_reg, (i % 2) ? 5 : 6);
      end
      tick();
    end
    b_valid = 0;
    #1 chk("t2_a_last", a_ready, 1);
    chk("t2_write_reg4", write_reg, 6);
    tick(); a_valid = 0;
    #1 chk("t2_write_reg5", write_reg, 5);
    chk("t2_reg_write5", reg_write, 1);
    tick();

    // Write to r0 is accepted but never enabled.
    b_valid = 1; b_reg = 0; b_data = 32'hFFFF0000;
    #1 chk("t3_b_ready", b_ready, 1);
    tick(); b_valid = 0;
    #1 chk("t3_reg_write", reg_write, 0);
    chk("t3_write_reg", write_reg, 0);
    chk("t3_write_data", write_data, 32'hFFFF0000);
    tick();
    chk("t3_rf0", rf[0], 0);

    // Scoreboard set, set-beats-clear collision, then plain clear.
    issue_valid = 1; issue_reg = 30;
    tick(); issue_valid = 0; a_valid = 1; a_reg = 30; a_data = 32'h3030_3030;
    #1 chk("t4_busy_set", busy[30], 1);
    tick(); a_valid = 0; issue_valid = 1; issue_reg = 30;
    #1 chk("t4_write", reg_write, 1);
    tick(); issue_valid = 0; a_valid = 1; a_reg = 30; a_data = 32'h3131_3131;
    #1 chk("t4_busy_collide", busy[30], 1);
    tick(); a_valid = 0;
    tick();
    #1 chk("t4_busy_clear", busy[30], 0);

    // Async reset in the middle of a WRITE cycle to r1.
    a_valid = 1; a_reg = 1; a_data = 32'h0000DEAD; issue_valid = 1; issue_reg = 9;
    tick(); a_valid = 0; issue_valid = 0;
    #1 chk("t5_write", reg_write, 1);
    chk("t5_busy9", busy[9], 1);
    #1 rst = 1;
    #1 chk("t5_rw_drop", reg_write, 0);
    chk("t5_busy_drop", busy, 0);
    tick(); rst = 0;
    chk("t5_rf1", rf[1], 0);

`ifdef REGFILE_ARB_FWD_EN
    fwd_reg = 7; a_valid = 1; a_reg = 7; a_data = 32'h12345678;
    #1 chk("t6_hit_pre", fwd_hit, 0);
    tick(); a_valid = 0;
    #1 chk("t6_hit", fwd_hit, 1);
    chk("t6_data", fwd_data, 32'h12345678);
    fwd_reg = 0;
    #1 chk("t6_hit_r0", fwd_hit, 0);
    chk("t6_data_r0", fwd_data, 0);
    fwd_reg = 7;
    tick();
    #1 chk("t6_hit_post", fwd_hit, 0);
`endif

    // Randomized traffic; requesters hold their request until accepted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      a_took = a_ready; b_took = b_ready;
      @(posedge clk);
      #1;
      if (!(a_valid && !a_took)) begin
        a_valid = ($urandom_range(0, 99) < 55);
        a_reg = 5'($urandom_range(0, 31)); a_data = $urandom;
      end
      if (!(b_valid && !b_took)) begin
        b_valid = ($urandom_range(0, 99) < 55);
        b_reg = 5'($urandom_range(0, 31)); b_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 99) < 40);
      issue_reg = 5'($urandom_range(0, 31));
`ifdef REGFILE_ARB_FWD_EN
      fwd_reg = ($urandom_range(0, 1) == 1) ? write_reg : 5'($urandom_range(0, 31));
`endif
    end
    @(negedge clk);
    a_took = a_ready; b_took = b_ready;
    @(posedge clk);
    #1;
    // Drain: let any waiting requester finish before going quiet.
    for (int k = 0; k < 4 && ((a_valid && !a_took) || (b_valid && !b_took)); k++) begin
      if (a_took) a_valid = 0;
      if (b_took) b_valid = 0;
      issue_valid = 0;
      @(negedge clk);
      a_took = a_ready; b_took = b_ready;
      @(posedge clk);
      #1;
    end
    a_valid = 0; b_valid = 0; issue_valid = 0;
    repeat (3) tick();
    for (int r = 0; r < 32; r++)
      chk("rf_final", rf[r], exp_rf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
